// File: rtl/start_for_srl_fifo_ctrl.sv
// Start-token FIFO: shift-register store read through an address pointer to the oldest entry.
// Optional START_FIFO_LEVEL_EN exposes the registered occupancy on port level.
module start_for_srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C   = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Handshake: a write is taken when if_write & if_write_ce & if_full_n, a read
    // when if_read & if_read_ce & if_empty_n, both on the rising edge of clk;
    // requests blocked by a deasserted flag are dropped without side effect.
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign wr = if_write & if_write_ce & if_full_n;
    assign rd = if_read  & if_read_ce  & if_empty_n;

    // Store is deliberately unreset; the flags hide stale contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                store[i] <= store[i-1];
            end
            store[0] <= if_din;
        end
    end

    assign if_dout = store[addr];

    always_comb begin
        count_next = count;
        addr_next  = addr;
        if (wr && !rd) begin
            count_next = count + COUNT_ONE;
            if (count != '0) begin
                addr_next = addr + 1'b1;
            end
        end else if (rd && !wr) begin
            count_next = count - COUNT_ONE;
            if (count != COUNT_ONE) begin
                addr_next = addr - 1'b1;
            end
        end
    end

    // Flags are computed from the next count so they move on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            addr       <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= count_next;
            addr       <= addr_next;
            if_empty_n <= (count_next != '0);
            if_full_n  <= (count_next < DEPTH_C);
        end
    end

`ifdef START_FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_start_for_srl_fifo_ctrl.sv
// Randomised and directed bench for start_for_srl_fifo_ctrl against a queue-based FIFO model.
module tb_start_for_srl_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_write_ce = 1'b1;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b1;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
`ifdef START_FIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  start_for_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .if_write_ce(if_write_ce),
    .if_write(if_write),
    .if_din(if_din),
    .if_full_n(if_full_n),
    .if_read_ce(if_read_ce),
    .if_read(if_read),
    .if_dout(if_dout),
    .if_empty_n(if_empty_n)
`ifdef START_FIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: the FIFO contents, oldest at index 0
  logic [DW-1:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      automatic bit acc_wr = if_write && if_write_ce && (exp_q.size() < DEPTH);
      automatic bit acc_rd = if_read && if_read_ce && (exp_q.size() > 0);
      if (acc_rd) void'(exp_q.pop_front());
      if (acc_wr) exp_q.push_back(if_din);
    end
  end

  // hand-computed pins for the directed phase
  logic          check_en = 1'b0;
  logic          pin_en = 1'b0;
  logic          pin_empty_n, pin_full_n, pin_dout_en;
  logic [DW-1:0] pin_dout;
  int            pin_level;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check("empty_n", {31'd0, if_empty_n}, {31'd0, exp_q.size() > 0});
      check("full_n", {31'd0, if_full_n}, {31'd0, exp_q.size() < DEPTH});
      if (exp_q.size() > 0) check("dout", {24'd0, if_dout}, {24'd0, exp_q[0]});
`ifdef START_FIFO_LEVEL_EN
      check("level", {30'd0, level}, exp_q.size());
`endif
      if (pin_en) begin
        check("pin_empty_n", {31'd0, if_empty_n}, {31'd0, pin_empty_n});
        check("pin_full_n", {31'd0, if_full_n}, {31'd0, pin_full_n});
        check("pin_model_level", exp_q.size(), pin_level);
        if (pin_dout_en) check("pin_dout", {24'd0, if_dout}, {24'd0, pin_dout});
`ifdef START_FIFO_LEVEL_EN
        check("pin_level", {30'd0, level}, pin_level);
`endif
      end
    end
  end

  // driver: one cycle of inputs plus the state expected to be visible in that cycle
  task automatic cyc(input logic w, input logic wce, input logic [DW-1:0] d,
                     input logic r, input logic rce,
                     input logic e_n, input logic f_n, input logic de,
                     input logic [DW-1:0] dv, input int lv);
    @(posedge clk);
    #1;
    if_write = w; if_write_ce = wce; if_din = d;
    if_read = r; if_read_ce = rce;
    pin_en = 1'b1; pin_empty_n = e_n; pin_full_n = f_n;
    pin_dout_en = de; pin_dout = dv; pin_level = lv;
  endtask

  initial begin
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_en = 1'b1;

    // reset / idle / read on empty
    cyc(0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0);
    // fill and drain in order
    cyc(1, 1, 8'hA1, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 1, 8'hB2, 0, 1, 1, 1, 1, 8'hA1, 1);
    cyc(0, 1, 8'h00, 1, 1, 1, 0, 1, 8'hA1, 2);
    cyc(0, 1, 8'h00, 1, 1, 1, 1, 1, 8'hB2, 1);
    // full with simultaneous write and read: only the read is taken
    cyc(1, 1, 8'hA1, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 1, 8'hB2, 0, 1, 1, 1, 1, 8'hA1, 1);
    cyc(1, 1, 8'hC3, 1, 1, 1, 0, 1, 8'hA1, 2);
    cyc(0, 1, 8'h00, 1, 1, 1, 1, 1, 8'hB2, 1);
    // count 1 with simultaneous write and read
    cyc(1, 1, 8'h11, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 1, 8'h22, 1, 1, 1, 1, 1, 8'h11, 1);
    cyc(0, 1, 8'h00, 1, 1, 1, 1, 1, 8'h22, 1);
    // empty with simultaneous write and read: only the write is taken
    cyc(1, 1, 8'h5A, 1, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 1, 8'hA1, 0, 1, 1, 1, 1, 8'h5A, 1);
    cyc(0, 1, 8'h00, 0, 1, 1, 0, 1, 8'h5A, 2);

    // asynchronous reset mid-cycle while full
    @(posedge clk);
    #1 pin_en = 1'b0;
    #2 reset = 1'b1;
    pin_en = 1'b1; pin_empty_n = 1'b0; pin_full_n = 1'b1; pin_dout_en = 1'b0; pin_level = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 0, 8'h77, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 0, 8'h88, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0);
    cyc(1, 1, 8'h3C, 0, 0, 0, 1, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 1, 0, 1, 1, 1, 8'h3C, 1);
    cyc(0, 1, 8'h00, 1, 1, 1, 1, 1, 8'h3C, 1);

    // randomised traffic with occasional async reset
    @(posedge clk);
    #1 pin_en = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      if_write    = ($urandom_range(0, 99) < 60);
      if_write_ce = ($urandom_range(0, 9) != 0);
      if_din      = DW'($urandom);
      if_read     = ($urandom_range(0, 99) < 55);
      if_read_ce  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(posedge clk);
    #1 reset = 1'b0; if_write = 1'b0; if_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
